// File: rtl/pll_lock_supervisor.sv
// rPLL bring-up sequencer: reset pulse, lock wait with retries,
// lock qualification, run-mode loss detection and event counters.
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYC    = 27,
  parameter int LOCK_TIMEOUT_CYC = 2700,
  parameter int LOCK_STABLE_CYC  = 256,
  parameter int LOST_FILTER      = 4,
  parameter int MAX_RETRY        = 7
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       sys_rst_n,
  output logic       locked_ok,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] lost_cnt
);

  localparam int M0 = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ?
                      RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
  localparam int M1 = (M0 > LOCK_STABLE_CYC) ? M0 : LOCK_STABLE_CYC;
  localparam int M2 = (M1 > LOST_FILTER) ? M1 : LOST_FILTER;
  localparam int CW = $clog2(M2 + 1);

  localparam logic [CW-1:0] RP_END = CW'(RST_PULSE_CYC - 1);
  localparam logic [CW-1:0] TO_END = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] ST_END = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [CW-1:0] LF_END = CW'(LOST_FILTER - 1);
  localparam logic [3:0]    RT_MAX = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [3:0]    retry_d;
  logic [7:0]    lost_d;
  logic          lock_m, lock_s;
  logic          pll_reset_d, sys_rst_n_d, fail_d;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= lock;
      lock_s <= lock_m;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt + CW'(1);
    retry_d = retry_cnt;
    lost_d  = lost_cnt;
    unique case (state)
      S_RESET_PLL: begin
        if (cnt == RP_END) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_STABLE;
        end else if (cnt == TO_END) begin
          if (retry_cnt == RT_MAX) begin
            state_d = S_FAIL;
          end else begin
            retry_d = retry_cnt + 4'd1;
            state_d = S_RESET_PLL;
          end
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt == ST_END) begin
          retry_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // cnt is the consecutive lock-low streak here
        if (lock_s) begin
          cnt_d = '0;
        end else if (cnt == LF_END) begin
          if (lost_cnt != 8'hFF) lost_d = lost_cnt + 8'd1;
          state_d = S_RESET_PLL;
        end
      end
      S_FAIL: begin
        cnt_d = '0;
      end
      default: begin
        state_d = S_RESET_PLL;
      end
    endcase
    if (state_d != state) cnt_d = '0;
    if (restart) begin
      state_d = S_RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end
    pll_reset_d = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
    sys_rst_n_d = (state_d == S_RUN);
    fail_d      = (state_d == S_FAIL);
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RESET_PLL;
      cnt       <= '0;
      retry_cnt <= '0;
      lost_cnt  <= '0;
      pll_reset <= 1'b1;
      sys_rst_n <= 1'b0;
      locked_ok <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      retry_cnt <= retry_d;
      lost_cnt  <= lost_d;
      pll_reset <= pll_reset_d;
      sys_rst_n <= sys_rst_n_d;
      locked_ok <= sys_rst_n_d;
      fail      <= fail_d;
    end
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Sequences the Gowin rPLL from the 27 MHz reference domain. It pulses the PLL reset, waits for `lock` with a timeout and bounded retries, and qualifies lock over a stability window. Only then does it release the downstream system reset. In run mode it watches for lock loss, recovers automatically, and counts events for status readout.

## Interface
Parameters:
- `RST_PULSE_CYC`, 27: cycles `pll_reset` is held high per attempt (1 us at 27 MHz).
- `LOCK_TIMEOUT_CYC`, 2700: cycles allowed in WAIT_LOCK before retry (100 us).
- `LOCK_STABLE_CYC`, 256: consecutive synchronized-lock cycles required before release.
- `LOST_FILTER`, 4: consecutive lock-low cycles in RUN that count as lock loss.
- `MAX_RETRY`, 7: retries after the first attempt before FAIL.

Ports:
- `clkin`, in, 1: reference clock. Single clock for the whole block.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `lock`, in, 1: PLL lock, asynchronous to `clkin`; 2-flop synchronized internally to `lock_s`.
- `restart`, in, 1: single-cycle request to re-run the full sequence.
- `pll_reset`, out, 1: to the rPLL RESET pin; active high.
- `sys_rst_n`, out, 1: downstream reset, active low; high only in RUN.
- `locked_ok`, out, 1: high in RUN.
- `fail`, out, 1: high in FAIL.
- `retry_cnt`, out, 4: retries used in the current sequence.
- `lost_cnt`, out, 8: lock-loss events since reset; saturates at 255.

## Operation
- All outputs are registered. Reset values:
  - state = RESET_PLL
  - `pll_reset`=1, `sys_rst_n`=0, `locked_ok`=0, `fail`=0
  - `retry_cnt`=0, `lost_cnt`=0, cycle counter `cnt`=0, sync flops=0
- One shared counter `cnt`, cleared on every state change. Width covers the largest parameter.
- **RESET_PLL:** `pll_reset`=1. When `cnt`==`RST_PULSE_CYC`-1, go to WAIT_LOCK.
- **WAIT_LOCK:** `pll_reset`=0.
  - `lock_s`=1 → STABLE.
  - Else if `cnt`==`LOCK_TIMEOUT_CYC`-1:
    - `retry_cnt`==`MAX_RETRY` → FAIL.
    - Otherwise `retry_cnt`++ and go to RESET_PLL.
- **STABLE:**
  - `lock_s`=0 → WAIT_LOCK. The timeout restarts from 0; `retry_cnt` is unchanged.
  - `cnt`==`LOCK_STABLE_CYC`-1 with `lock_s`=1 → RUN; `retry_cnt` cleared.
- **RUN:** `sys_rst_n`=1, `locked_ok`=1.
  - `cnt` counts consecutive `lock_s`=0 cycles and clears on any `lock_s`=1.
  - When it reaches `LOST_FILTER`-1 with `lock_s`=0: `lost_cnt`++ (saturating), then → RESET_PLL.
- **FAIL:** `pll_reset`=1, `fail`=1, `sys_rst_n`=0. Stays here until `restart`.
- `restart`=1 in any state → RESET_PLL with `retry_cnt`=0 and `cnt`=0. `lost_cnt` is not changed. `restart` has priority over every other transition in the same cycle.
- Glitches on `lock` in RUN shorter than `LOST_FILTER` cycles (after sync) are ignored.

## Timing
- `lock` → `lock_s` latency is 2 `clkin` edges.
- Output registers update on the same edge as the state register. Example: `sys_rst_n` rises on the edge that enters RUN and falls on the edge that leaves RUN.
- Best case from `rst_n` release with `lock` already high: `sys_rst_n` rises after `RST_PULSE_CYC` + 1 + `LOCK_STABLE_CYC` edges, since `lock_s` settles during RESET_PLL.
- Lock loss in RUN: `sys_rst_n` falls `LOST_FILTER` edges after `lock_s` first reads 0, i.e. `LOST_FILTER`+2 edges after `lock` falls.
- Worst case to FAIL: (`MAX_RETRY`+1)·(`RST_PULSE_CYC`+`LOCK_TIMEOUT_CYC`) edges.
- Async `rst_n` assertion forces reset values immediately, mid-sequence included. Deassertion is sampled on the next `clkin` edge.

## Test plan
Parameters for all scenarios: `RST_PULSE_CYC`=4, `LOCK_TIMEOUT_CYC`=32, `LOCK_STABLE_CYC`=8, `LOST_FILTER`=3, `MAX_RETRY`=2.

- **Normal lock:** `lock` rises 10 cycles after reset release → `pll_reset` high exactly 4 cycles, `sys_rst_n` rises exactly 8 edges after entering STABLE, `retry_cnt`=0, `fail`=0.
- **No lock:** `lock` held 0 → three `pll_reset` pulses of 4 cycles each; `retry_cnt` goes 1, then 2; `fail`=1 after 108 edges; `sys_rst_n` stays 0.
- **Flicker during qualification:** `lock` high 5 cycles, low 1, high again → returns to WAIT_LOCK, then STABLE again; release requires a fresh 8 consecutive cycles.
- **Run-mode glitch vs. real loss:** `lock` low for 2 cycles → no effect, `lost_cnt`=0. `lock` low for 3 cycles → `sys_rst_n` falls, `lost_cnt`=1, new `pll_reset` pulse, re-lock releases again.
- **Restart from FAIL:** `restart` pulse while in FAIL, then `lock`=1 → `fail` clears next edge, `retry_cnt`=0, normal release.
- **Mid-sequence reset:** `rst_n` low during STABLE → outputs return to reset values without waiting for a clock edge.
